// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// data_mem_responder: M-stage memory responder with programmable wait states.
// Services LW/SW against a 16-word array and raises stall while an access is in flight.
module data_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [65:0] m_in,
  output logic [31:0] m_out,
  output logic        stall
);

  localparam int unsigned MEM_ADDR_WIDTH = 4;
  localparam int unsigned DEPTH          = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Request fields: {read, write, addr[31:0], val[31:0]}
  logic                      in_read;
  logic                      in_write;
  logic [31:0]               in_addr;
  logic [DATA_W-1:0]         in_val;
  logic [MEM_ADDR_WIDTH-1:0] in_idx;
  logic                      req;
  logic                      unused_addr_bits;

  assign in_read          = m_in[65];
  assign in_write         = m_in[64];
  assign in_addr          = m_in[63:32];
  assign in_val           = m_in[31:0];
  assign in_idx           = in_addr[MEM_ADDR_WIDTH+1:2];
  assign req              = in_read | in_write;
  assign unused_addr_bits = ^{in_addr[31:MEM_ADDR_WIDTH+2], in_addr[1:0]};

  state_t                    state, state_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic                      lat_rd, lat_wr;
  logic [MEM_ADDR_WIDTH-1:0] lat_idx;
  logic [DATA_W-1:0]         lat_val;
  logic [DATA_W-1:0]         rdata;
  logic [DATA_W-1:0]         mem [DEPTH];

  logic                      lat_load;
  logic                      done;
  logic                      op_rd, op_wr;
  logic [MEM_ADDR_WIDTH-1:0] op_idx;
  logic [DATA_W-1:0]         op_val;

  // Next-state, stall and completion decode; read-with-write is treated as write only
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    stall    = 1'b0;
    lat_load = 1'b0;
    done     = 1'b0;
    op_rd    = lat_rd;
    op_wr    = lat_wr;
    op_idx   = lat_idx;
    op_val   = lat_val;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            done   = 1'b1;
            op_rd  = in_read & ~in_write;
            op_wr  = in_write;
            op_idx = in_idx;
            op_val = in_val;
          end else begin
            stall    = 1'b1;
            lat_load = 1'b1;
            state_d  = BUSY;
            cnt_d    = CNT_W'(WAIT_CYCLES - 1);
          end
        end else begin
          op_rd = 1'b0;
          op_wr = 1'b0;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          stall = 1'b1;
          cnt_d = cnt - CNT_W'(1);
          op_rd = 1'b0;
          op_wr = 1'b0;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        op_rd   = 1'b0;
        op_wr   = 1'b0;
      end
    endcase
  end

  // Load data is visible in the completion cycle so the MW register captures it on the same edge
  always_comb begin
    m_out = rdata;
    if (done && op_rd) begin
      m_out = mem[op_idx];
    end
  end

  // State, request latch, memory array and read-data register; reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_rd  <= 1'b0;
      lat_wr  <= 1'b0;
      lat_idx <= '0;
      lat_val <= '0;
      rdata   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (lat_load) begin
        lat_rd  <= in_read & ~in_write;
        lat_wr  <= in_write;
        lat_idx <= in_idx;
        lat_val <= in_val;
      end
      if (done && op_wr) begin
        mem[op_idx] <= op_val;
      end
      if (done && op_rd) begin
        rdata <= mem[op_idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// Bench for data_mem_responder: three instances (WAIT_CYCLES 0, 1, 3) each checked every
// cycle against a transaction-level model (accept time + latency), plus literal spot checks.
module tb_data_mem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] m_in  [N];
  logic [31:0] m_out [N];
  logic        stall [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int unsigned wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // DUT instances and their reference models
  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int unsigned WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    data_mem_responder #(.WAIT_CYCLES(WC)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .m_in  (m_in[g]),
      .m_out (m_out[g]),
      .stall (stall[g])
    );

    logic [31:0] mdl_mem [16];
    logic [31:0] mdl_rdata;
    bit          pend;
    logic [65:0] pend_req;
    int unsigned done_cyc;
    int unsigned cyc;

    // A request accepted at cycle t completes at t+WC; stall covers cycles t..t+WC-1
    always @(negedge clk) begin : model
      bit          complete;
      bit          exp_stall;
      bit          is_rd, is_wr;
      int unsigned idx;
      logic [31:0] exp_out;
      if (rst) begin
        check($sformatf("reset_stall_w%0d", WC), 32'(stall[g]), 32'd0);
        check($sformatf("reset_m_out_w%0d", WC), m_out[g], 32'd0);
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;
        mdl_rdata = 32'd0;
        pend      = 1'b0;
        pend_req  = '0;
        cyc       = 0;
        done_cyc  = 0;
      end else begin
        if (!pend && (m_in[g][65] || m_in[g][64])) begin
          pend     = 1'b1;
          pend_req = m_in[g];
          done_cyc = cyc + WC;
        end
        exp_stall = pend && (cyc < done_cyc);
        complete  = pend && (cyc == done_cyc);
        is_wr     = pend_req[64];
        is_rd     = pend_req[65] && !pend_req[64];
        idx       = (pend_req[63:32] >> 2) % 32'd16;
        exp_out   = (complete && is_rd) ? mdl_mem[idx] : mdl_rdata;
        check($sformatf("model_stall_w%0d_c%0d", WC, cyc), 32'(stall[g]), 32'(exp_stall));
        check($sformatf("model_m_out_w%0d_c%0d", WC, cyc), m_out[g], exp_out);
        if (complete) begin
          if (is_wr) mdl_mem[idx] = pend_req[31:0];
          else       mdl_rdata    = mdl_mem[idx];
          pend = 1'b0;
        end
        cyc++;
      end
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  // Drive one access on instance k starting now (posedge+1), return at posedge+1 after completion
  task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] val, input bit scramble, input bit chk,
                        input logic [31:0] exp_out);
    int unsigned wc;
    logic [95:0] r;
    wc = wc_of(k);
    m_in[k] = {rd, wr, addr, val};
    for (int i = 1; i <= int'(wc); i++) begin
      @(negedge clk);
      if (i == 1) check($sformatf("stall_accept_k%0d", k), 32'(stall[k]), 32'd1);
      cyc_step();
      if (scramble) begin
        r = {$urandom, $urandom, $urandom};
        m_in[k] = r[65:0];
      end else begin
        m_in[k] = '0;
      end
    end
    @(negedge clk);
    check($sformatf("stall_complete_k%0d", k), 32'(stall[k]), 32'd0);
    if (chk) check($sformatf("m_out_complete_k%0d_a%08h", k, addr), m_out[k], exp_out);
    cyc_step();
    m_in[k] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int          sel;
    rst = 1'b0;
    for (int k = 0; k < N; k++) m_in[k] = '0;
    #1 rst = 1'b1;
    cyc_step();
    cyc_step();
    rst = 1'b0;

    // SW 0x8 then LW 0x8 with one wait state; load value held afterwards
    access(1, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check("m_out_held", m_out[1], 32'hDEADBEEF);
    cyc_step();

    // Three wait states, inputs scrambled while busy
    access(2, 1'b0, 1'b1, 32'h10, 32'h12345678, 1'b1, 1'b0, 32'h0);
    access(2, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    access(2, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h12345678);

    // Aliasing, and read+write together acting as a write
    access(1, 1'b0, 1'b1, 32'h44, 32'h5, 1'b0, 1'b0, 32'h0);
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'h5);
    access(1, 1'b1, 1'b1, 32'h4, 32'h77, 1'b0, 1'b1, 32'h5);
    access(1, 1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b0, 1'b1, 32'h77);

    // Zero wait states: alternating SW/LW every cycle
    for (int i = 0; i < 8; i++) begin
      v = 32'h1111_0000 + 32'(i);
      access(0, 1'b0, 1'b1, 32'(4 * i), v, 1'b0, 1'b0, 32'h0);
      access(0, 1'b1, 1'b0, 32'(4 * i), 32'h0, 1'b0, 1'b1, v);
    end

    // Reset in the middle of a write
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    m_in[2] = {1'b0, 1'b1, 32'h30, 32'h0BADC0DE};
    @(negedge clk);
    cyc_step();
    m_in[2] = '0;
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(stall[2]), 32'd0);
    check("rst_mid_m_out", m_out[2], 32'd0);
    check("rst_mid_m_out_k1", m_out[1], 32'd0);
    @(negedge clk);
    cyc_step();
    rst = 1'b0;
    access(2, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h0);
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h0);

    // Random traffic on each instance, checked by the models
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 80; n++) begin
        sel = int'($urandom_range(0, 4));
        a = $urandom;
        a[5:2] = 4'($urandom_range(0, 5));
        v = $urandom;
        case (sel)
          0:       cyc_step();
          1, 2:    access(k, 1'b0, 1'b1, a, v, 1'($urandom), 1'b0, 32'h0);
          3:       access(k, 1'b1, 1'b0, a, v, 1'($urandom), 1'b0, 32'h0);
          default: access(k, 1'b1, 1'b1, a, v, 1'($urandom), 1'b0, 32'h0);
        endcase
      end
    end

    cyc_step();
    cyc_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
